pipemem_burst: RTL
==================

# pipemem_burst

Block-transfer issue stage that sits directly upstream of the pipelined memory unit `pipemem`. It accepts one load-multiple or store-multiple request (base address, word count, first register) from the CPU decode/execute path. It then emits one `i_pipe_stb` per word into the memory unit, honouring its stall, and reads store data from the register file. It signals completion or bus error back to the CPU once the memory unit has drained.

## Interface
Parameters:
- AW, 32, address width driven to the memory unit.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_stb  in  1  burst request; accepted only when o_busy=0.
- i_op  in  1  0=load, 1=store.
- i_addr  in  AW  base word address.
- i_len  in  4  words minus one (1..16 words).
- i_reg  in  5  first register of the burst.
- o_busy  out  1  burst in progress.
- o_done  out  1  one-cycle pulse, burst completed without error.
- o_err  out  1  one-cycle pulse, burst aborted on bus error.
- o_rdreg  out  5  register-file read index (store data).
- i_rddata  in  32  register-file data for o_rdreg, combinational same cycle.
- o_pipe_stb  out  1  per-word strobe to the memory unit.
- o_op  out  1  operation to the memory unit.
- o_addr  out  AW  word address to the memory unit.
- o_data  out  32  store data (= i_rddata).
- o_oreg  out  5  destination register tag for loads.
- i_pipe_stalled  in  1  memory unit cannot accept a strobe this cycle.
- i_mem_busy  in  1  memory unit bus cycle active.
- i_mem_err  in  1  memory unit error pulse.

## Operation
- States: IDLE, ISSUE, GUARD, DRAIN.
- IDLE: on i_stb, latch op, cur_addr=i_addr, cur_reg=i_reg, remaining=i_len, then go to ISSUE. i_stb while busy is ignored, with no queueing.
- ISSUE: o_pipe_stb = !i_pipe_stalled (combinational, registers only on the stall path).
  - Each strobe advances cur_addr+1 (AW-bit wrap) and cur_reg+1 (5-bit wrap, 31→0), and decrements remaining.
  - A strobe with remaining==0 is the last; go to GUARD.
- GUARD: one cycle that waits for the memory unit's registered busy to reflect the last strobe; go to DRAIN.
- DRAIN: when i_mem_busy=0, pulse o_done and return to IDLE.
- o_oreg = o_rdreg = cur_reg; o_addr = cur_addr; o_op = latched op; o_data = i_rddata.
- Error: i_mem_err in ISSUE, GUARD or DRAIN pulses o_err next cycle and returns to IDLE. No further strobes are issued, including in the cycle of the error, and o_done is not pulsed. i_mem_err in IDLE is ignored.
- Loads and stores are never mixed within one burst. A new burst cannot start until the memory unit is idle; DRAIN guarantees this.
- Outstanding count never exceeds 16, the capacity of the memory unit's tag FIFO.

## Timing
- Reset: state=IDLE; o_busy=0, o_done=0, o_err=0, o_pipe_stb=0. cur_addr, cur_reg and remaining are cleared to 0. i_rst mid-burst aborts immediately with no o_done and no o_err pulse.
- Request accepted at edge T, so o_busy=1 from cycle T+1. The first o_pipe_stb can occur in cycle T+1.
- Unstalled N-word burst: strobes in cycles T+1..T+N, GUARD at T+N+1, DRAIN from T+N+2.
  - o_done is high in the first cycle after DRAIN sees i_mem_busy=0.
  - o_busy is 0 in that same cycle, so a new i_stb is accepted in that cycle.
- Stall: while i_pipe_stalled=1 there is no strobe. Address, register and remaining are held, and o_data follows the held o_rdreg.
- o_done and o_err are mutually exclusive, each exactly one cycle.
- i_mem_err and the last strobe in the same cycle: the strobe is suppressed, and the error takes priority.

## Test plan
- Load burst: i_addr=0x1000, i_len=3, i_reg=2, no stall.
  - Required: strobes in 4 consecutive cycles with addr 0x1000..0x1003 and oreg 2..5.
  - o_done pulses once after the memory unit's busy falls, and o_err stays 0.
- Store burst with stall: i_len=1, i_reg=31, i_pipe_stalled high for 3 cycles after the first strobe.
  - Required: second strobe only after the stall clears, with o_rdreg=0 (wrap).
  - o_data equals the register-file value for regs 31 and 0.
- Single word: i_len=0.
  - Required: exactly one strobe, GUARD, then o_done.
  - A back-to-back i_stb in the o_done cycle is accepted.
- Bus error: i_mem_err asserted after 2 of 8 strobes.
  - Required: no further strobes, o_err pulses one cycle later, no o_done, o_busy=0.
- Reset mid-burst: i_rst during ISSUE of a 16-word burst.
  - Required: next cycle all outputs 0, state IDLE.
  - A subsequent 16-word burst issues 16 strobes with addresses contiguous and wrapping at 2^AW.
- Ignored request: i_stb while o_busy=1.
  - Required: no effect on address, count or completion of the current burst.

Source files
------------

// File: rtl/pipemem_burst.sv
// Block-transfer issue stage: turns one load/store-multiple request into a
// stream of per-word strobes for the pipelined memory unit, then waits for it to drain.
module pipemem_burst #(
  parameter int AW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_stb,
  input  logic          i_op,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_len,
  input  logic [4:0]    i_reg,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [4:0]    o_rdreg,
  input  logic [31:0]   i_rddata,
  output logic          o_pipe_stb,
  output logic          o_op,
  output logic [AW-1:0] o_addr,
  output logic [31:0]   o_data,
  output logic [4:0]    o_oreg,
  input  logic          i_pipe_stalled,
  input  logic          i_mem_busy,
  input  logic          i_mem_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    r_state;
  logic          r_op;
  logic [AW-1:0] r_addr;
  logic [4:0]    r_reg;
  logic [3:0]    r_rem;
  logic          r_done;
  logic          r_err;

  logic w_issue;
  logic w_last;

  // A bus error in the same cycle blocks the strobe, so nothing new enters the memory unit.
  assign w_issue = (r_state == S_ISSUE) && !i_pipe_stalled && !i_mem_err;
  assign w_last  = w_issue && (r_rem == 4'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_op    <= 1'b0;
      r_addr  <= '0;
      r_reg   <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_stb) begin
            r_op    <= i_op;
            r_addr  <= i_addr;
            r_reg   <= i_reg;
            r_rem   <= i_len;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_mem_err) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_issue) begin
            r_addr <= r_addr + AW'(1);
            r_reg  <= r_reg + 5'd1;
            r_rem  <= r_rem - 4'd1;
            if (w_last) r_state <= S_GUARD;
          end
        end
        // The memory unit's busy is registered, so it lags the last strobe by a cycle.
        S_GUARD: begin
          if (i_mem_err) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (i_mem_err) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (!i_mem_busy) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_pipe_stb = w_issue;
  assign o_op       = r_op;
  assign o_addr     = r_addr;
  assign o_rdreg    = r_reg;
  assign o_oreg     = r_reg;
  assign o_data     = i_rddata;

endmodule
